camera_pixel_packer: RTL and testbench

CAMERA_PIXEL_PACKER -- requirements
Module: camera_pixel_packer

---
 rtl/camera_pixel_packer.sv | 167 ++++++++++++++++
 tb/tb_camera_pixel_packer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_pixel_packer.sv
//==============================================================================
// Module   : camera_pixel_packer
// Brief    : Packs camera byte stream (U,Y0,V,Y1) into 32-bit YUV pair words.
// Revision : 1.0
//==============================================================================
`default_nettype none

module camera_pixel_packer #(
  parameter int H_PAIRS = 320,
  parameter int V_LINES = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [31:0] yuv,
  output logic        yuv_valid,
  output logic [9:0]  pair_x,
  output logic [9:0]  line_y,
  output logic        frame_start,
  output logic        line_err
);

  localparam logic [10:0] C_H_PAIRS = 11'(H_PAIRS);
  localparam logic [10:0] C_V_LINES = 11'(V_LINES);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    SYNC      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  logic [2:0]  pclk_q;
  logic [2:0]  vsync_q;
  logic [2:0]  href_q;
  logic [7:0]  data_s1_q;
  logic [7:0]  data_s2_q;

  state_t      state_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  u_q;
  logic [7:0]  y0_q;
  logic [7:0]  v_q;
  logic [31:0] yuv_q;
  logic        yuv_valid_q;
  logic [9:0]  pair_x_q;
  logic [9:0]  line_y_q;
  logic        frame_start_q;
  logic        line_err_q;
  logic        line_has_byte_q;

  logic        pclk_rise_w;
  logic        vsync_s_w;
  logic        vsync_rise_w;
  logic        vsync_fall_w;
  logic        href_s_w;
  logic        href_fall_w;
  logic [9:0]  pair_x_d;
  logic [9:0]  line_y_d;
  logic        word_oob_w;

  // Bit 0 is the first synchronizer stage; bit 2 is the edge-detect history.
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_q    <= 3'b000;
      vsync_q   <= 3'b000;
      href_q    <= 3'b000;
      data_s1_q <= 8'h00;
      data_s2_q <= 8'h00;
    end else begin
      pclk_q    <= {pclk_q[1:0], cam_pclk};
      vsync_q   <= {vsync_q[1:0], cam_vsync};
      href_q    <= {href_q[1:0], cam_href};
      data_s1_q <= cam_data;
      data_s2_q <= data_s1_q;
    end
  end

  assign pclk_rise_w  = pclk_q[1] & ~pclk_q[2];
  assign vsync_s_w    = vsync_q[1];
  assign vsync_rise_w = vsync_q[1] & ~vsync_q[2];
  assign vsync_fall_w = ~vsync_q[1] & vsync_q[2];
  assign href_s_w     = href_q[1];
  assign href_fall_w  = ~href_q[1] & href_q[2];

  assign pair_x_d   = (pair_x_q == 10'h3FF) ? pair_x_q : pair_x_q + 10'd1;
  assign line_y_d   = (line_y_q == 10'h3FF) ? line_y_q : line_y_q + 10'd1;
  assign word_oob_w = ({1'b0, pair_x_q} >= C_H_PAIRS) || ({1'b0, line_y_q} >= C_V_LINES);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= WAIT_SYNC;
      byte_idx_q      <= 2'd0;
      u_q             <= 8'h00;
      y0_q            <= 8'h00;
      v_q             <= 8'h00;
      yuv_q           <= 32'h0;
      yuv_valid_q     <= 1'b0;
      pair_x_q        <= 10'd0;
      line_y_q        <= 10'd0;
      frame_start_q   <= 1'b0;
      line_err_q      <= 1'b0;
      line_has_byte_q <= 1'b0;
    end else begin
      yuv_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      // Coordinates advance only after the pulse so they describe the emitted word.
      if (yuv_valid_q) pair_x_q <= pair_x_d;

      case (state_q)
        WAIT_SYNC: begin
          byte_idx_q <= 2'd0;
          if (vsync_s_w) state_q <= SYNC;
        end
        SYNC: begin
          if (vsync_fall_w) begin
            state_q         <= ACTIVE;
            frame_start_q   <= 1'b1;
            line_y_q        <= 10'd0;
            pair_x_q        <= 10'd0;
            byte_idx_q      <= 2'd0;
            line_has_byte_q <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vsync_rise_w) begin
            state_q         <= SYNC;
            byte_idx_q      <= 2'd0;
            line_has_byte_q <= 1'b0;
          end else if (href_fall_w) begin
            if (byte_idx_q != 2'd0 || {1'b0, pair_x_q} != C_H_PAIRS) line_err_q <= 1'b1;
            byte_idx_q      <= 2'd0;
            pair_x_q        <= 10'd0;
            line_has_byte_q <= 1'b0;
            if (line_has_byte_q) line_y_q <= line_y_d;
          end else if (pclk_rise_w && href_s_w) begin
            line_has_byte_q <= 1'b1;
            byte_idx_q      <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: u_q  <= data_s2_q;
              2'd1: y0_q <= data_s2_q;
              2'd2: v_q  <= data_s2_q;
              default: begin
                yuv_q       <= {v_q, y0_q, u_q, data_s2_q};
                yuv_valid_q <= 1'b1;
                if (word_oob_w) line_err_q <= 1'b1;
              end
            endcase
          end
        end
        default: state_q <= WAIT_SYNC;
      endcase
    end
  end

  assign yuv         = yuv_q;
  assign yuv_valid   = yuv_valid_q;
  assign pair_x      = pair_x_q;
  assign line_y      = line_y_q;
  assign frame_start = frame_start_q;
  assign line_err    = line_err_q;

endmodule

`default_nettype wire

// File: tb/tb_camera_pixel_packer.sv
//==============================================================================
// Module   : tb_camera_pixel_packer
// Brief    : Directed self-checking bench for camera_pixel_packer (H=4, V=3).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_camera_pixel_packer;

  localparam int H = 4;
  localparam int V = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [31:0] yuv;
  logic        yuv_valid;
  logic [9:0]  pair_x;
  logic [9:0]  line_y;
  logic        frame_start;
  logic        line_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mon_yuv[$];
  logic [9:0]  mon_x[$];
  logic [9:0]  mon_y[$];
  int          fs_cnt = 0;

  camera_pixel_packer #(.H_PAIRS(H), .V_LINES(V)) dut (
    .clk(clk), .rst(rst), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
    .cam_href(cam_href), .cam_data(cam_data), .yuv(yuv), .yuv_valid(yuv_valid),
    .pair_x(pair_x), .line_y(line_y), .frame_start(frame_start), .line_err(line_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (yuv_valid) begin
      mon_yuv.push_back(yuv);
      mon_x.push_back(pair_x);
      mon_y.push_back(line_y);
    end
    if (frame_start) fs_cnt++;
  end

  function automatic logic [7:0] pat(int l, int w, int k);
    return 8'(l * 53 + w * 17 + k * 5 + 3);
  endfunction

  function automatic logic [31:0] exp_word(int l, int w);
    return {pat(l, w, 2), pat(l, w, 1), pat(l, w, 0), pat(l, w, 3)};
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_yuv.delete();
    mon_x.delete();
    mon_y.delete();
    fs_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(1);
    clear_mon();
  endtask

  task automatic send_byte(logic [7:0] b);
    cam_data = b;
    tick(2);
    cam_pclk = 1'b1;
    tick(2);
    cam_pclk = 1'b0;
  endtask

  task automatic send_word(int l, int w, bit gaps);
    for (int k = 0; k < 4; k++) begin
      send_byte(pat(l, w, k));
      if (gaps) tick($urandom_range(0, 3));
    end
  endtask

  task automatic line_begin();
    cam_href = 1'b1;
    tick(2);
  endtask

  task automatic line_end();
    cam_href = 1'b0;
    tick(8);
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    tick(8);
    cam_vsync = 1'b0;
    tick(8);
  endtask

  task automatic send_line(int l, bit gaps);
    line_begin();
    for (int w = 0; w < H; w++) send_word(l, w, gaps);
    line_end();
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick(1);
    n_checks++;
    if ({yuv, yuv_valid, pair_x, line_y, frame_start, line_err} !== 55'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got yuv=%h v=%b x=%0d y=%0d fs=%b err=%b, want all 0",
               yuv, yuv_valid, pair_x, line_y, frame_start, line_err);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_first_word();
    do_reset();
    vsync_pulse();
    n_checks++;
    if (fs_cnt !== 1) begin n_fail++; $display("FAIL first_frame_start: got %0d want 1", fs_cnt); end
    line_begin();
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
    line_end();
    n_checks++;
    if (mon_yuv.size() !== 1) begin
      n_fail++; $display("FAIL first_count: got %0d want 1", mon_yuv.size());
    end else begin
      n_checks++;
      if (mon_yuv[0] !== 32'h3020_1040 || mon_x[0] !== 10'd0 || mon_y[0] !== 10'd0) begin
        n_fail++;
        $display("FAIL first_word: got %h x=%0d y=%0d want 30201040 x=0 y=0",
                 mon_yuv[0], mon_x[0], mon_y[0]);
      end
    end
    n_checks++;
    if (line_err !== 1'b1) begin n_fail++; $display("FAIL short_line_err: got %b want 1", line_err); end
  endtask

  task automatic test_full_line();
    do_reset();
    vsync_pulse();
    send_line(0, 1'b0);
    n_checks++;
    if (mon_yuv.size() !== H) begin
      n_fail++; $display("FAIL full_count: got %0d want %0d", mon_yuv.size(), H);
    end else begin
      for (int w = 0; w < H; w++) begin
        n_checks++;
        if (mon_yuv[w] !== exp_word(0, w) || mon_x[w] !== 10'(w) || mon_y[w] !== 10'd0) begin
          n_fail++;
          $display("FAIL full_word%0d: got %h x=%0d y=%0d want %h x=%0d y=0",
                   w, mon_yuv[w], mon_x[w], mon_y[w], exp_word(0, w), w);
        end
      end
    end
    clear_mon();
    send_line(1, 1'b0);
    n_checks++;
    if (mon_yuv.size() !== H || mon_y[0] !== 10'd1 || mon_x[0] !== 10'd0) begin
      n_fail++;
      $display("FAIL second_line: got n=%0d y=%0d x=%0d want n=%0d y=1 x=0",
               mon_yuv.size(), mon_y[0], mon_x[0], H);
    end
    n_checks++;
    if (line_err !== 1'b0) begin n_fail++; $display("FAIL full_line_err: got %b want 0", line_err); end
  endtask

  task automatic test_long_line();
    do_reset();
    vsync_pulse();
    line_begin();
    for (int w = 0; w <= H; w++) send_word(0, w, 1'b0);
    send_byte(8'hAA); send_byte(8'hBB);
    line_end();
    n_checks++;
    if (mon_yuv.size() !== H + 1 || mon_x[H] !== 10'(H)) begin
      n_fail++;
      $display("FAIL long_count: got n=%0d lastx=%0d want n=%0d lastx=%0d",
               mon_yuv.size(), mon_x[mon_yuv.size()-1], H + 1, H);
    end
    n_checks++;
    if (line_err !== 1'b1) begin n_fail++; $display("FAIL long_line_err: got %b want 1", line_err); end
    clear_mon();
    send_line(1, 1'b0);
    n_checks++;
    if (mon_yuv.size() !== H || mon_yuv[0] !== exp_word(1, 0) || mon_x[0] !== 10'd0 || mon_y[0] !== 10'd1) begin
      n_fail++;
      $display("FAIL after_long: got n=%0d %h x=%0d y=%0d want n=%0d %h x=0 y=1",
               mon_yuv.size(), mon_yuv[0], mon_x[0], mon_y[0], H, exp_word(1, 0));
    end
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (line_err !== 1'b0 || line_y !== 10'd0 || yuv !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_clears: got err=%b y=%0d yuv=%h want 0", line_err, line_y, yuv);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_reset_midframe();
    rst = 1'b1; cam_vsync = 1'b0; cam_pclk = 1'b0;
    line_begin();
    send_byte(8'h01); send_byte(8'h02);
    rst = 1'b0;
    clear_mon();
    for (int k = 0; k < 6; k++) send_byte(8'(k + 3));
    line_end();
    send_line(0, 1'b0);
    n_checks++;
    if (mon_yuv.size() !== 0 || fs_cnt !== 0) begin
      n_fail++;
      $display("FAIL midframe_silent: got words=%0d fs=%0d want 0 0", mon_yuv.size(), fs_cnt);
    end
    vsync_pulse();
    send_line(0, 1'b0);
    n_checks++;
    if (fs_cnt !== 1 || mon_yuv.size() !== H || mon_yuv[0] !== exp_word(0, 0) || mon_y[0] !== 10'd0) begin
      n_fail++;
      $display("FAIL midframe_resume: got fs=%0d n=%0d %h y=%0d want fs=1 n=%0d %h y=0",
               fs_cnt, mon_yuv.size(), mon_yuv[0], mon_y[0], H, exp_word(0, 0));
    end
  endtask

  task automatic test_vsync_partial();
    do_reset();
    vsync_pulse();
    send_line(0, 1'b0);
    clear_mon();
    line_begin();
    send_byte(8'h55); send_byte(8'h66);
    cam_vsync = 1'b1;
    tick(8);
    cam_href = 1'b0;
    tick(8);
    cam_vsync = 1'b0;
    tick(8);
    n_checks++;
    if (mon_yuv.size() !== 0 || fs_cnt !== 1) begin
      n_fail++;
      $display("FAIL partial_drop: got words=%0d fs=%0d want 0 1", mon_yuv.size(), fs_cnt);
    end
    n_checks++;
    if (line_err !== 1'b0) begin n_fail++; $display("FAIL partial_err: got %b want 0", line_err); end
    send_line(0, 1'b0);
    n_checks++;
    if (mon_yuv.size() !== H || mon_yuv[0] !== exp_word(0, 0) || mon_x[0] !== 10'd0 || mon_y[0] !== 10'd0) begin
      n_fail++;
      $display("FAIL partial_next: got n=%0d %h x=%0d y=%0d want n=%0d %h x=0 y=0",
               mon_yuv.size(), mon_yuv[0], mon_x[0], mon_y[0], H, exp_word(0, 0));
    end
  endtask

  task automatic test_full_frame();
    int idx;
    do_reset();
    vsync_pulse();
    for (int l = 0; l < V; l++) begin
      send_line(l, 1'b1);
      tick($urandom_range(0, 10));
    end
    n_checks++;
    if (mon_yuv.size() !== V * H) begin
      n_fail++; $display("FAIL frame_count: got %0d want %0d", mon_yuv.size(), V * H);
    end else begin
      for (int l = 0; l < V; l++) begin
        for (int w = 0; w < H; w++) begin
          idx = l * H + w;
          n_checks++;
          if (mon_yuv[idx] !== exp_word(l, w) || mon_x[idx] !== 10'(w) || mon_y[idx] !== 10'(l)) begin
            n_fail++;
            $display("FAIL frame_word l%0d w%0d: got %h x=%0d y=%0d want %h x=%0d y=%0d",
                     l, w, mon_yuv[idx], mon_x[idx], mon_y[idx], exp_word(l, w), w, l);
          end
        end
      end
    end
    n_checks++;
    if (line_err !== 1'b0) begin n_fail++; $display("FAIL frame_err: got %b want 0", line_err); end
    clear_mon();
    send_line(V, 1'b0);
    n_checks++;
    if (mon_yuv.size() !== H || mon_y[0] !== 10'(V) || line_err !== 1'b1) begin
      n_fail++;
      $display("FAIL extra_line: got n=%0d y=%0d err=%b want n=%0d y=%0d err=1",
               mon_yuv.size(), mon_y[0], line_err, H, V);
    end
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_full_line();
    test_long_line();
    test_reset_midframe();
    test_vsync_partial();
    test_full_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
